// File: rtl/scrambler_58_stream.sv
// rtl/scrambler_58_stream.sv - self-synchronous x^58+x^39+1 scrambler/descrambler stream stage
//
// Ports:
//   CLK, RST_N            clock (rising edge) and synchronous active-low reset
//   seed_load, seed_value run-time load of the 58-bit LFSR (blocks input for that cycle)
//   s_valid/s_ready/s_data  input beat, bit 0 earliest on the serial line
//   m_valid/m_ready/m_data  registered output beat
//   lfsr_state            current LFSR S[57:0], S[0] = most recent bit
//   beat_cnt              accepted input beats, wraps silently at 2^32
module scrambler_58_stream #(
  parameter int          DATA_W     = 64,
  parameter int          DESCRAMBLE = 0,
  parameter logic [57:0] SEED       = {58{1'b1}}
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              seed_load,
  input  logic [57:0]       seed_value,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [57:0]       lfsr_state,
  output logic [31:0]       beat_cnt
);

  logic [57:0]       lfsr_q, lfsr_d;
  logic [57:0]       lfsr_w;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q;
  logic [31:0]       beat_cnt_q;
  logic              xfer;

  // The output register can take a new beat when empty or draining this cycle;
  // a seed load blocks input so the new seed is never mixed with a beat.
  assign s_ready = ~seed_load & (~m_valid_q | m_ready);
  assign xfer    = s_valid & s_ready;

  // Bit-serial recurrence unrolled over the beat. For DATA_W > 58 later bits
  // tap bits shifted in earlier in the same beat, which the running lfsr_w
  // handles naturally.
  always_comb begin
    lfsr_w   = lfsr_q;
    m_data_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      m_data_d[i] = s_data[i] ^ lfsr_w[38] ^ lfsr_w[57];
      lfsr_w      = {lfsr_w[56:0], (DESCRAMBLE != 0) ? s_data[i] : m_data_d[i]};
    end
    lfsr_d = lfsr_w;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lfsr_q     <= SEED;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (seed_load) begin
        lfsr_q <= seed_value;
      end else if (xfer) begin
        lfsr_q <= lfsr_d;
      end
      if (xfer) begin
        m_valid_q  <= 1'b1;
        m_data_q   <= m_data_d;
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign lfsr_state = lfsr_q;
  assign beat_cnt   = beat_cnt_q;

endmodule
